dp_sequencer: RTL and testbench
===============================

Name: dp_sequencer

Overview:
Multicycle control FSM for the ARM32 execute datapath. It accepts one 32-bit ARM data-processing instruction per valid/ready handshake, decodes it, and evaluates its condition code against the datapath status flags. It then drives the datapath's operand-register enables, mux selects, shifter/ALU controls, status enable and register-file write port, over a fixed DECODE -> EXECUTE -> WRITEBACK sequence. It sits between the fetch stage and the datapath, in the pre-pipeline CPU.

Parameters:
DATA_W, 32, datapath word width
RADDR_W, 4, register address width (16 architectural registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  fetch presents an instruction
instr_ready  out  1  sequencer can accept (IDLE only)
instr  in  DATA_W  ARM instruction word
status_flags  in  DATA_W  datapath status register; [31:28] = N,Z,C,V
A_addr, B_addr, shift_addr  out  RADDR_W  register-file read addresses (Rn, Rm, Rs)
en_A, en_B, en_S  out  1  operand-register load enables
sel_A  out  1  1 = force ALU A operand to 0
sel_B  out  1  1 = immediate B operand, 0 = shifter output
sel_shift  out  1  1 = shift amount from register Rs, 0 = shift_imme
shift_op  out  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shift_imme  out  DATA_W  zero-extended 5-bit immediate shift amount
imme_data  out  DATA_W  rotated immediate operand
ALU_op  out  3  ALU operation
en_status  out  1  load status register
wb_sel  out  1  write-back source select; 0 = ALU result (always 0 for data-processing)
w_addr1  out  RADDR_W  write-back register (Rd)
w_en1  out  1  register-file write enable
done  out  1  one-cycle retire pulse
skipped  out  1  with done: condition failed
illegal  out  1  with done: unsupported opcode

Behaviour:
- Reset (async): state=IDLE, captured instruction=0, all outputs 0. instr_ready is 0 while rst=1 and 1 in IDLE after release.
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instr_ready=1. If instr_valid=1, capture instr and go to DECODE. Otherwise stay in IDLE.
- Busy states (DECODE, EXECUTE, WRITEBACK): instr_ready=0. instr_valid is ignored, and instr may change without effect.
- DECODE, cycle T+1 after acceptance at T:
  - Drive A_addr=instr[19:16], B_addr=instr[3:0], shift_addr=instr[11:8].
  - Assert en_A, en_B, en_S.
  - Evaluate cond instr[31:28] against status_flags. Support all 15 ARM conditions, EQ..AL; 1111 counts as a condition fail.
  - Condition fail: done=1, skipped=1, go to IDLE; no en_status, no w_en1.
  - Unsupported opcode: done=1, illegal=1, go to IDLE; no en_status, no w_en1.
  - Otherwise go to EXECUTE.
- Opcode map, instr[24:21] -> ALU_op:
  - AND 0000 -> 010
  - EOR 0001 -> 100
  - SUB 0010 -> 001
  - ADD 0100 -> 000
  - CMP 1010 -> 001, no write-back, en_status forced on
  - ORR 1100 -> 011
  - MOV 1101 -> 000 with sel_A=1
  - All other opcodes are illegal.
- Operand 2:
  - instr[25]=1 (immediate): sel_B=1, imme_data = ror(zero-extend(instr[7:0]), 2*instr[11:8]).
  - instr[25]=0 (register): sel_B=0, shift_op=instr[6:5].
    - instr[4]=0: sel_shift=0, shift_imme = instr[11:7].
    - instr[4]=1: sel_shift=1.
- Control-signal timing: operand/shift controls are valid from DECODE through WRITEBACK. ALU_op and sel_A/sel_B are valid in EXECUTE and WRITEBACK, held stable so ALU_out is stable at the write edge.
- EXECUTE, T+2: en_status=1 for one cycle if instr[20]=1 or the opcode is CMP. Go to WRITEBACK.
- WRITEBACK, T+3: w_en1=1 and w_addr1=instr[15:12] unless CMP; wb_sel=0; done=1. Go to IDLE.
- Throughput: next instruction accepted at T+4.
- Reset mid-operation aborts immediately. No partial write occurs after rst rises.

Decomposition:
- Package dp_ctrl_pkg holds:
  - state enum
  - ALU_op constants
  - ARM opcode constants
  - cond-code constants
  - shift_op constants
- One sub-module: dp_cond_eval, purely combinational (cond[3:0], NZCV) -> pass.
- The immediate rotator stays inline.

Test Plan:
- ADD r1,r2,#5 (0xE2821005), all flags 0:
  - DECODE at T+1: A_addr=2, en_A=1.
  - EXECUTE at T+2: sel_B=1, imme_data=0x00000005, ALU_op=000, en_status=0.
  - WRITEBACK at T+3: w_en1=1, w_addr1=1, done=1.
- MOV r0,#0xFF000000 (0xE3A004FF): imme_data=0xFF000000, sel_A=1, ALU_op=000, w_addr1=0, w_en1 in WRITEBACK.
- SUBS r3,r4,r5,LSL r6 (0xE0543615):
  - DECODE: A_addr=4, B_addr=5, shift_addr=6, sel_shift=1, shift_op=00.
  - EXECUTE: en_status=1, ALU_op=001.
  - WRITEBACK: w_en1=1, w_addr1=3.
- ADDEQ (0x02821005) with status_flags[30]=0: done=1, skipped=1 at T+1; w_en1 and en_status never asserted; instr_ready=1 at T+2. Repeat with Z=1: full sequence executes.
- Unsupported opcode 0011 (0xE0621003): illegal=1, done=1 at T+1, no writes. CMP r2,r3 (0xE1520003): en_status=1, w_en1 stays 0.
- rst pulsed during EXECUTE: all outputs 0 immediately, no w_en1. After release, instr_ready=1. instr_valid held high during a busy instruction is not accepted until IDLE.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the ARM32 data-processing sequencer.
package dp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_e;

  // ALU operation encodings seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // ARM data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  // ARM condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Shifter operations
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu_op;
  } op_dec_t;

  // Map an ARM opcode to its ALU operation; unsupported opcodes are not legal
  function automatic op_dec_t decode_op(input logic [3:0] opc);
    op_dec_t d;
    d.legal  = 1'b1;
    d.alu_op = ALU_ADD;
    case (opc)
      OP_AND:  d.alu_op = ALU_AND;
      OP_EOR:  d.alu_op = ALU_EOR;
      OP_SUB:  d.alu_op = ALU_SUB;
      OP_ADD:  d.alu_op = ALU_ADD;
      OP_CMP:  d.alu_op = ALU_SUB;
      OP_ORR:  d.alu_op = ALU_ORR;
      OP_MOV:  d.alu_op = ALU_ADD;
      default: d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dp_cond_eval.sv
// ARM condition-code evaluator: (cond, NZCV) -> pass. 1111 never passes.
module dp_cond_eval
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  // Evaluate the condition against the flags
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multicycle DECODE -> EXECUTE -> WRITEBACK control FSM for ARM32
// data-processing instructions. All datapath controls are decoded
// combinationally from the captured instruction and current state.
module dp_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [DATA_W-1:0]  instr,
  input  logic [DATA_W-1:0]  status_flags,
  output logic [RADDR_W-1:0] A_addr,
  output logic [RADDR_W-1:0] B_addr,
  output logic [RADDR_W-1:0] shift_addr,
  output logic               en_A,
  output logic               en_B,
  output logic               en_S,
  output logic               sel_A,
  output logic               sel_B,
  output logic               sel_shift,
  output logic [1:0]         shift_op,
  output logic [DATA_W-1:0]  shift_imme,
  output logic [DATA_W-1:0]  imme_data,
  output logic [2:0]         ALU_op,
  output logic               en_status,
  output logic               wb_sel,
  output logic [RADDR_W-1:0] w_addr1,
  output logic               w_en1,
  output logic               done,
  output logic               skipped,
  output logic               illegal
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;

  logic        cond_pass;
  op_dec_t     op_dec;
  logic        is_cmp;
  logic        imm_op;
  logic [4:0]  rot_amt;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] imm_rot;
  logic        unused_bits;

  assign op_dec  = decode_op(instr_q[24:21]);
  assign is_cmp  = (instr_q[24:21] == OP_CMP);
  assign imm_op  = instr_q[25];
  assign rot_amt = {instr_q[11:8], 1'b0};
  assign imm_ext = DATA_W'(instr_q[7:0]);
  // A shift by DATA_W yields zero, so rot_amt == 0 leaves imm_ext unchanged
  assign imm_rot = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - 32'(rot_amt)));

  assign unused_bits = ^{status_flags[DATA_W-5:0], instr_q[27:26]};

  dp_cond_eval u_cond (
    .cond_i (instr_q[31:28]),
    .nzcv_i (status_flags[DATA_W-1 -: 4]),
    .pass_o (cond_pass)
  );

  // State and captured-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state: accept in IDLE, retire early on cond fail / illegal opcode
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE:    state_d = (cond_pass && op_dec.legal) ? ST_EXECUTE : ST_IDLE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs: operand/shift controls in all busy states, ALU controls from EXECUTE
  always_comb begin
    instr_ready = 1'b0;
    A_addr      = '0;
    B_addr      = '0;
    shift_addr  = '0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    sel_shift   = 1'b0;
    shift_op    = SH_LSL;
    shift_imme  = '0;
    imme_data   = '0;
    ALU_op      = ALU_ADD;
    en_status   = 1'b0;
    wb_sel      = 1'b0;
    w_addr1     = '0;
    w_en1       = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;

    if (state_q == ST_IDLE) begin
      instr_ready = !rst;
    end else begin
      A_addr     = RADDR_W'(instr_q[19:16]);
      B_addr     = RADDR_W'(instr_q[3:0]);
      shift_addr = RADDR_W'(instr_q[11:8]);
      if (imm_op) begin
        imme_data = imm_rot;
      end else begin
        shift_op  = instr_q[6:5];
        sel_shift = instr_q[4];
        if (!instr_q[4]) shift_imme = DATA_W'(instr_q[11:7]);
      end
    end

    case (state_q)
      ST_DECODE: begin
        en_A    = 1'b1;
        en_B    = 1'b1;
        en_S    = 1'b1;
        skipped = !cond_pass;
        illegal = cond_pass && !op_dec.legal;
        done    = !cond_pass || !op_dec.legal;
      end
      ST_EXECUTE, ST_WRITEBACK: begin
        ALU_op = op_dec.alu_op;
        sel_A  = (instr_q[24:21] == OP_MOV);
        sel_B  = imm_op;
        if (state_q == ST_EXECUTE) begin
          en_status = instr_q[20] || is_cmp;
        end else begin
          done  = 1'b1;
          w_en1 = !is_cmp;
          if (!is_cmp) w_addr1 = RADDR_W'(instr_q[15:12]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed, table-driven bench for dp_sequencer.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] status_flags;
  logic [3:0]  A_addr, B_addr, shift_addr, w_addr1;
  logic        en_A, en_B, en_S, sel_A, sel_B, sel_shift;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme, imme_data;
  logic [2:0]  ALU_op;
  logic        en_status, wb_sel, w_en1, done, skipped, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dp_sequencer #(.DATA_W(32), .RADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .status_flags (status_flags),
    .A_addr       (A_addr),
    .B_addr       (B_addr),
    .shift_addr   (shift_addr),
    .en_A         (en_A),
    .en_B         (en_B),
    .en_S         (en_S),
    .sel_A        (sel_A),
    .sel_B        (sel_B),
    .sel_shift    (sel_shift),
    .shift_op     (shift_op),
    .shift_imme   (shift_imme),
    .imme_data    (imme_data),
    .ALU_op       (ALU_op),
    .en_status    (en_status),
    .wb_sel       (wb_sel),
    .w_addr1      (w_addr1),
    .w_en1        (w_en1),
    .done         (done),
    .skipped      (skipped),
    .illegal      (illegal)
  );

  // Every output except instr_ready, OR-reduced
  logic any_out;
  assign any_out = |{A_addr, B_addr, shift_addr, en_A, en_B, en_S, sel_A, sel_B,
                     sel_shift, shift_op, shift_imme, imme_data, ALU_op, en_status,
                     wb_sel, w_addr1, w_en1, done, skipped, illegal};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] flags;
    logic        skip;
    logic        ill;
    logic [3:0]  a, b, s;
    logic        sel_shift;
    logic [1:0]  shop;
    logic [31:0] shimm;
    logic [31:0] imme;
    logic        sel_a, sel_b;
    logic [2:0]  alu;
    logic        ens, wen;
    logic [3:0]  waddr;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction at a negedge in IDLE and check every phase
  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    instr        = v.instr;
    status_flags = v.flags;
    instr_valid  = 1'b1;
    check({p, "_idle_ready"}, 32'(instr_ready), 32'd1);
    next_cycle();
    instr_valid = 1'b0;
    instr       = $urandom;
    // DECODE
    check({p, "_dec_ready"}, 32'(instr_ready), 32'd0);
    check({p, "_dec_en"}, 32'({en_A, en_B, en_S}), 32'd7);
    check({p, "_dec_A"}, 32'(A_addr), 32'(v.a));
    check({p, "_dec_B"}, 32'(B_addr), 32'(v.b));
    check({p, "_dec_S"}, 32'(shift_addr), 32'(v.s));
    check({p, "_dec_sel_shift"}, 32'(sel_shift), 32'(v.sel_shift));
    check({p, "_dec_shift_op"}, 32'(shift_op), 32'(v.shop));
    check({p, "_dec_shift_imme"}, shift_imme, v.shimm);
    check({p, "_dec_imme"}, imme_data, v.imme);
    check({p, "_dec_done"}, 32'(done), 32'(v.skip || v.ill));
    check({p, "_dec_skipped"}, 32'(skipped), 32'(v.skip));
    check({p, "_dec_illegal"}, 32'(illegal), 32'(v.ill));
    check({p, "_dec_wr"}, 32'({en_status, w_en1}), 32'd0);
    if (!(v.skip || v.ill)) begin
      next_cycle();
      // EXECUTE
      check({p, "_ex_en_status"}, 32'(en_status), 32'(v.ens));
      check({p, "_ex_alu"}, 32'(ALU_op), 32'(v.alu));
      check({p, "_ex_sel_A"}, 32'(sel_A), 32'(v.sel_a));
      check({p, "_ex_sel_B"}, 32'(sel_B), 32'(v.sel_b));
      check({p, "_ex_imme"}, imme_data, v.imme);
      check({p, "_ex_A"}, 32'(A_addr), 32'(v.a));
      check({p, "_ex_quiet"}, 32'({en_A, w_en1, done, instr_ready}), 32'd0);
      next_cycle();
      // WRITEBACK
      check({p, "_wb_w_en1"}, 32'(w_en1), 32'(v.wen));
      check({p, "_wb_w_addr1"}, 32'(w_addr1), 32'(v.waddr));
      check({p, "_wb_done"}, 32'({done, skipped, illegal}), 32'b100);
      check({p, "_wb_alu"}, 32'(ALU_op), 32'(v.alu));
      check({p, "_wb_sel_B"}, 32'(sel_B), 32'(v.sel_b));
      check({p, "_wb_misc"}, 32'({wb_sel, en_status, instr_ready}), 32'd0);
    end
    next_cycle();
    check({p, "_end_ready"}, 32'(instr_ready), 32'd1);
    check({p, "_end_outs"}, 32'(any_out), 32'd0);
  endtask

  initial begin
    //            instr          flags          skip  ill   A     B     S     sshf  shop   shimm  imme           selA  selB  alu     ens   wen   wad
    vecs[0]  = '{32'hE2821005, 32'h00000000, 1'b0, 1'b0, 4'd2, 4'd5, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000005, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 4'd1};
    vecs[1]  = '{32'hE3A004FF, 32'h00000000, 1'b0, 1'b0, 4'd0, 4'hF, 4'd4, 1'b0, 2'd0, 32'd0,  32'hFF000000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 4'd0};
    vecs[2]  = '{32'hE0543615, 32'h00000000, 1'b0, 1'b0, 4'd4, 4'd5, 4'd6, 1'b1, 2'd0, 32'd0,  32'h00000000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 4'd3};
    vecs[3]  = '{32'h02821005, 32'h00000000, 1'b1, 1'b0, 4'd2, 4'd5, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000005, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 4'd1};
    vecs[4]  = '{32'h02821005, 32'h40000000, 1'b0, 1'b0, 4'd2, 4'd5, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000005, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 4'd1};
    vecs[5]  = '{32'hE0621003, 32'h00000000, 1'b0, 1'b1, 4'd2, 4'd3, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{32'hE1520003, 32'h00000000, 1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'd0};
    vecs[7]  = '{32'hC18871C9, 32'h00000000, 1'b0, 1'b0, 4'd8, 4'd9, 4'd1, 1'b0, 2'd2, 32'd3,  32'h00000000, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 4'd7};
    vecs[8]  = '{32'hC18871C9, 32'h80000000, 1'b1, 1'b0, 4'd8, 4'd9, 4'd1, 1'b0, 2'd2, 32'd3,  32'h00000000, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 4'd7};
    vecs[9]  = '{32'hF2821005, 32'hF0000000, 1'b1, 1'b0, 4'd2, 4'd5, 4'd0, 1'b0, 2'd0, 32'd0,  32'h00000005, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 4'd1};
    vecs[10] = '{32'hE2365FAB, 32'h00000000, 1'b0, 1'b0, 4'd6, 4'hB, 4'hF, 1'b0, 2'd0, 32'd0,  32'h000002AC, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 4'd5};
    vecs[11] = '{32'h80011FA2, 32'h20000000, 1'b0, 1'b0, 4'd1, 4'd2, 4'hF, 1'b0, 2'd1, 32'd31, 32'h00000000, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 4'd1};

    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr        = '0;
    status_flags = '0;
    #2;
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_outs", 32'(any_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset during EXECUTE aborts without a write
    instr        = 32'hE2821005;
    status_flags = '0;
    instr_valid  = 1'b1;
    next_cycle();
    instr_valid = 1'b0;
    next_cycle();
    check("abort_in_execute", 32'(ALU_op == 3'b000 && sel_B && !en_A), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_outs", 32'(any_out), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd0);
    next_cycle();
    check("abort_no_wen", 32'(w_en1), 32'd0);
    check("abort_outs2", 32'(any_out), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_release_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);

    // instr_valid held high while busy: second instruction waits for IDLE
    instr       = 32'hE2821005;
    instr_valid = 1'b1;
    next_cycle();
    instr = 32'hE3A004FF;
    check("busy_dec_ready", 32'(instr_ready), 32'd0);
    check("busy_dec_A", 32'(A_addr), 32'd2);
    next_cycle();
    check("busy_ex_ready", 32'(instr_ready), 32'd0);
    check("busy_ex_imme", imme_data, 32'h00000005);
    next_cycle();
    check("busy_wb_ready", 32'(instr_ready), 32'd0);
    check("busy_wb_w_addr1", 32'(w_addr1), 32'd1);
    check("busy_wb_done", 32'({done, w_en1}), 32'b11);
    next_cycle();
    check("busy_idle_ready", 32'(instr_ready), 32'd1);
    check("busy_idle_en_A", 32'(en_A), 32'd0);
    next_cycle();
    instr_valid = 1'b0;
    check("second_dec_en_A", 32'(en_A), 32'd1);
    check("second_dec_S", 32'(shift_addr), 32'd4);
    next_cycle();
    check("second_ex_sel_A", 32'(sel_A), 32'd1);
    check("second_ex_imme", imme_data, 32'hFF000000);
    next_cycle();
    check("second_wb", 32'({w_en1, w_addr1, done}), 32'b1_0000_1);
    next_cycle();
    check("second_end_ready", 32'(instr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
